// File: rtl/store_pkg.sv
// store_pkg
//   Shared types for the store write path: store-type encoding as issued by
//   the control unit, the store FSM state set, the datapath word width and the
//   alignment rule that decides whether a store is rejected.
package store_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_BAD = 2'b11
    } store_type_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        DONE,
        ERR
    } state_e;

    // A store is rejected when its type is undefined or its byte offset does
    // not fall on a natural boundary for its size. Byte stores always fit.
    function automatic logic is_bad_store(store_type_e t, logic [1:0] off);
        logic bad;
        case (t)
            ST_SW:   bad = (off != 2'b00);
            ST_SH:   bad = off[0];
            ST_SB:   bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lane_merge.sv
// lane_merge
//   Combinational little-endian lane insert for partial stores. Replaces the
//   byte or halfword lane selected by the byte offset with the low bits of
//   the store data; every other bit keeps the value of the old word.
//   Ports:
//     old_word    in   32  word read back from memory
//     data        in   32  store data (sh uses [15:0], sb uses [7:0])
//     byte_off    in   2   byte offset within the word
//     store_type  in   2   store kind (store_type_e)
//     new_word    out  32  merged word to write back
module lane_merge
    import store_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] data,
    input  logic [1:0]        byte_off,
    input  store_type_e       store_type,
    output logic [WORD_W-1:0] new_word
);

    always_comb begin
        new_word = old_word;
        case (store_type)
            ST_SW: new_word = data;
            ST_SH: begin
                if (byte_off[1]) new_word[31:16] = data[15:0];
                else             new_word[15:0]  = data[15:0];
            end
            ST_SB: begin
                case (byte_off)
                    2'd0:    new_word[7:0]   = data[7:0];
                    2'd1:    new_word[15:8]  = data[7:0];
                    2'd2:    new_word[23:16] = data[7:0];
                    default: new_word[31:24] = data[7:0];
                endcase
            end
            default: new_word = old_word;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// store_unit
//   Memory-side write path of the multicycle datapath. Accepts sw/sh/sb store
//   requests and turns them into single word writes on a word-addressed data
//   memory; sh/sb use read-modify-write. Misaligned or undefined stores are
//   rejected with a done+misaligned pulse and never touch memory.
//   Parameters:
//     MEM_LAT     data-memory read latency in cycles (1..4)
//   Ports:
//     clk         in   1   clock, rising edge
//     reset       in   1   asynchronous, active-low reset
//     req         in   1   store request, sampled only when idle
//     store_type  in   2   00=sw 01=sh 10=sb 11=invalid
//     addr        in   32  byte address of the store
//     wdata       in   32  store data
//     busy        out  1   operation in flight (through the done cycle)
//     done        out  1   one-cycle completion pulse
//     misaligned  out  1   one-cycle reject pulse, coincident with done
//     mem_addr    out  32  word-aligned memory address
//     mem_wr      out  1   one-cycle memory write strobe
//     mem_wdata   out  32  word written to memory
//     mem_rdata   in   32  memory read data
module store_unit
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        store_type,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int                CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0]  LAT_C = CNT_W'(MEM_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    store_type_e       type_q, type_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] word_q, word_d;

    logic              busy_d, done_d, mis_d, mem_wr_d;
    logic [WORD_W-1:0] mem_addr_d, mem_wdata_d;

    logic [WORD_W-1:0] merged;
    store_type_e       req_type;

    assign req_type = store_type_e'(store_type);

    lane_merge u_lane_merge (
        .old_word   (word_q),
        .data       (data_q),
        .byte_off   (addr_q[1:0]),
        .store_type (type_q),
        .new_word   (merged)
    );

    // Every output is registered, so a state's outputs appear during the
    // cycle that follows it. The done pulse is therefore visible while the
    // FSM is already back in IDLE; gating acceptance on done keeps a request
    // seen in the done cycle from being taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        type_d      = type_q;
        data_d      = data_q;
        word_d      = word_q;
        done_d      = 1'b0;
        mis_d       = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state_q)
            IDLE: begin
                if (req && !done) begin
                    addr_d = addr;
                    type_d = req_type;
                    data_d = wdata;
                    word_d = wdata;
                    cnt_d  = '0;
                    if (is_bad_store(req_type, addr[1:0])) state_d = ERR;
                    else if (req_type == ST_SW)            state_d = WRITE;
                    else                                   state_d = READ;
                end
            end
            READ: begin
                mem_addr_d = {addr_q[WORD_W-1:2], 2'b00};
                if (cnt_q == LAT_C) begin
                    word_d  = mem_rdata;
                    state_d = MERGE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MERGE: begin
                word_d  = merged;
                state_d = WRITE;
            end
            WRITE: begin
                mem_addr_d  = {addr_q[WORD_W-1:2], 2'b00};
                mem_wdata_d = word_q;
                mem_wr_d    = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                done_d  = 1'b1;
                mis_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            type_q     <= ST_SW;
            data_q     <= '0;
            word_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_addr   <= '0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            type_q     <= type_d;
            data_q     <= data_d;
            word_q     <= word_d;
            busy       <= busy_d;
            done       <= done_d;
            misaligned <= mis_d;
            mem_addr   <= mem_addr_d;
            mem_wr     <= mem_wr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit
//   Bench for store_unit. Two instances run side by side, one with a read
//   latency of 1 and one with 3, each backed by a read-only memory image whose
//   read data appears MEM_LAT cycles after mem_addr (counting the mem_addr
//   cycle). Directed vectors come from a table; reset-mid-write and held-req
//   cases are written out by hand.
module tb_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req [2];
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        busy [2];
    logic        done [2];
    logic        mis [2];
    logic        mem_wr [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    logic [31:0] memimg [16];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        store_unit #(.MEM_LAT(LAT)) u_dut (
            .clk        (clk),
            .reset      (rst_n),
            .req        (req[g]),
            .store_type (st),
            .addr       (addr),
            .wdata      (wdata),
            .busy       (busy[g]),
            .done       (done[g]),
            .misaligned (mis[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wr     (mem_wr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
        );

        if (LAT == 1) begin : g_comb
            assign mem_rdata[g] = memimg[mem_addr[g][5:2]];
        end else begin : g_pipe
            logic [31:0] pipe [LAT-1];
            always @(posedge clk) begin
                pipe[0] <= memimg[mem_addr[g][5:2]];
                for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
            end
            assign mem_rdata[g] = pipe[LAT-2];
        end
    end

    typedef struct {
        int          sel;
        logic [1:0]  ty;
        logic [31:0] a;
        logic [31:0] wd;
        bit          err;
        logic [31:0] e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag, input int g);
        check($sformatf("%s_busy%0d", tag, g),      32'(busy[g]),   32'd0);
        check($sformatf("%s_done%0d", tag, g),      32'(done[g]),   32'd0);
        check($sformatf("%s_mis%0d", tag, g),       32'(mis[g]),    32'd0);
        check($sformatf("%s_mem_wr%0d", tag, g),    32'(mem_wr[g]), 32'd0);
        check($sformatf("%s_mem_addr%0d", tag, g),  mem_addr[g],    32'd0);
        check($sformatf("%s_mem_wdata%0d", tag, g), mem_wdata[g],   32'd0);
    endtask

    // Issues one request on the selected instance (accepted at edge T) and
    // watches it for 12 cycles; k counts cycles after edge T.
    task automatic run_txn(input vec_t v, input int id);
        int lat;
        int exp_wr_k;
        int exp_done_k;
        int wr_cnt;
        int wr_k;
        int done_cnt;
        int done_k;
        int busy_err;
        logic mis_seen;
        logic [31:0] cap_a;
        logic [31:0] cap_d;

        lat      = (v.sel == 0) ? 1 : 3;
        wr_cnt   = 0;
        wr_k     = -1;
        done_cnt = 0;
        done_k   = -1;
        busy_err = 0;
        mis_seen = 1'b0;
        cap_a    = '0;
        cap_d    = '0;
        if (v.err) begin
            exp_wr_k   = -1;
            exp_done_k = 1;
        end else if (v.ty == 2'b00) begin
            exp_wr_k   = 1;
            exp_done_k = 2;
        end else begin
            exp_wr_k   = lat + 3;
            exp_done_k = lat + 4;
        end

        @(posedge clk); #1;
        req[v.sel] = 1'b1;
        st    = v.ty;
        addr  = v.a;
        wdata = v.wd;
        @(posedge clk); #1;
        req[v.sel] = 1'b0;
        st    = ~v.ty;
        addr  = ~v.a;
        wdata = ~v.wd;

        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (mem_wr[v.sel]) begin
                wr_cnt++;
                if (wr_k < 0) begin
                    wr_k  = k;
                    cap_a = mem_addr[v.sel];
                    cap_d = mem_wdata[v.sel];
                end
            end
            if (done[v.sel]) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k   = k;
                    mis_seen = mis[v.sel];
                end
            end
            if (busy[v.sel] !== (k <= exp_done_k)) busy_err++;
            if (mis[v.sel] && !done[v.sel]) busy_err++;
        end

        check($sformatf("v%0d_wr_count", id), 32'(wr_cnt), v.err ? 32'd0 : 32'd1);
        if (!v.err) begin
            check($sformatf("v%0d_wr_cycle", id), 32'(wr_k), 32'(exp_wr_k));
            check($sformatf("v%0d_mem_addr", id), cap_a, v.e_addr);
            check($sformatf("v%0d_mem_wdata", id), cap_d, v.e_data);
        end
        check($sformatf("v%0d_done_cycle", id), 32'(done_k), 32'(exp_done_k));
        check($sformatf("v%0d_done_count", id), 32'(done_cnt), 32'd1);
        check($sformatf("v%0d_misaligned", id), 32'(mis_seen), 32'(v.err));
        check($sformatf("v%0d_busy_profile", id), 32'(busy_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v_sw;
        int   found;

        for (int i = 0; i < 16; i++) memimg[i] = 32'hA5A5_0000 | 32'(i);
        memimg[0] = 32'hA5A5_5A5A;
        memimg[1] = 32'h1122_3344;
        memimg[8] = 32'h1122_3344;

        vecs[0]  = '{0, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF};
        vecs[1]  = '{0, 2'b10, 32'h0000_0023, 32'h0000_00AB, 1'b0, 32'h0000_0020, 32'hAB22_3344};
        vecs[2]  = '{0, 2'b01, 32'h0000_0006, 32'h0000_CAFE, 1'b0, 32'h0000_0004, 32'hCAFE_3344};
        vecs[3]  = '{0, 2'b01, 32'h0000_0005, 32'h0000_1234, 1'b1, 32'h0, 32'h0};
        vecs[4]  = '{0, 2'b00, 32'h0000_0002, 32'h1111_1111, 1'b1, 32'h0, 32'h0};
        vecs[5]  = '{0, 2'b11, 32'h0000_0000, 32'h2222_2222, 1'b1, 32'h0, 32'h0};
        vecs[6]  = '{0, 2'b10, 32'h0000_0020, 32'h0000_0055, 1'b0, 32'h0000_0020, 32'h1122_3355};
        vecs[7]  = '{0, 2'b10, 32'h0000_0021, 32'hFFFF_FF66, 1'b0, 32'h0000_0020, 32'h1122_6644};
        vecs[8]  = '{0, 2'b10, 32'h0000_0022, 32'h0000_0099, 1'b0, 32'h0000_0020, 32'h1199_3344};
        vecs[9]  = '{0, 2'b01, 32'h0000_0004, 32'h1234_BEEF, 1'b0, 32'h0000_0004, 32'h1122_BEEF};
        vecs[10] = '{0, 2'b01, 32'h0000_0002, 32'h0000_BEEF, 1'b0, 32'h0000_0000, 32'hBEEF_5A5A};
        vecs[11] = '{0, 2'b00, 32'hFFFF_FFFC, 32'h0BAD_F00D, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_F00D};
        vecs[12] = '{1, 2'b10, 32'h0000_0023, 32'h0000_00AB, 1'b0, 32'h0000_0020, 32'hAB22_3344};
        vecs[13] = '{1, 2'b01, 32'h0000_0006, 32'h0000_CAFE, 1'b0, 32'h0000_0004, 32'hCAFE_3344};
        vecs[14] = '{1, 2'b10, 32'h8000_0021, 32'h0000_0077, 1'b0, 32'h8000_0020, 32'h1122_7744};
        vecs[15] = '{1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF};
        vecs[16] = '{1, 2'b01, 32'h0000_0001, 32'h0000_5678, 1'b1, 32'h0, 32'h0};
        v_sw = vecs[0];

        rst_n  = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        st     = 2'b00;
        addr   = '0;
        wdata  = '0;

        repeat (3) @(posedge clk);
        #2;
        for (int g = 0; g < 2; g++) check_reset_outputs("reset", g);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 17; i++) run_txn(vecs[i], i);

        // Reset while the sb write strobe is on the bus.
        @(posedge clk); #1;
        req[0] = 1'b1;
        st     = 2'b10;
        addr   = 32'h0000_0023;
        wdata  = 32'h0000_00AB;
        @(posedge clk); #1;
        req[0] = 1'b0;
        found  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_wr[0]) begin
                found = 1;
                break;
            end
        end
        check("rst_wr_reached", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid", 0);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_quiet%0d", k), 32'({mem_wr[0], done[0], busy[0]}), 32'd0);
        end
        run_txn(v_sw, 100);

        // req held high with wdata changing every cycle: accept at edge 0,
        // write at 1, done at 2, ignored at 3, next accept at 4, and so on.
        @(posedge clk); #1;
        req[0] = 1'b1;
        st     = 2'b00;
        addr   = 32'h0000_0040;
        wdata  = 32'h1000_0000;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            wdata = 32'h1000_0000 + 32'(j + 1);
            @(negedge clk);
            check($sformatf("hold_wr%0d", j), 32'(mem_wr[0]), 32'((j % 4) == 1));
            check($sformatf("hold_done%0d", j), 32'(done[0]), 32'((j % 4) == 2));
            if ((j % 4) == 1) begin
                check($sformatf("hold_data%0d", j), mem_wdata[0], 32'h1000_0000 + 32'(j - 1));
                check($sformatf("hold_addr%0d", j), mem_addr[0], 32'h0000_0040);
            end
        end
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_idle_busy", 32'(busy[0]), 32'd0);
        check("other_idle_busy", 32'(busy[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
